// File: rtl/coffee_order_scheduler.sv
`timescale 1ns/1ps
// coffee_order_scheduler: round-robin order intake from N_REQ panels, order FIFO,
// and a dispatch FSM that runs the brewing FSM one order at a time.
//
// state   | meaning
// IDLE    | nothing in flight; move to ISSUE when an order is queued or being pushed
// ISSUE   | one-cycle start pulse, FIFO head selection latched into the hold register
// BREW    | selection held, waiting for brewer done or the timeout limit
// ABORT   | brewer held in reset for two cycles after a timeout
// RECOVER | wait for brewer IDLE, then GAP quiet cycles before the next issue
module coffee_order_scheduler #(
   parameter int N_REQ   = 3,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 32,
   parameter int GAP     = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             req,
   input  logic [2*N_REQ-1:0]           req_sel,
   output logic [N_REQ-1:0]             req_ack,
   output logic [N_REQ-1:0]             req_nack,
   output logic                         fsm_start,
   output logic [1:0]                   fsm_sel,
   output logic                         fsm_reset,
   input  logic                         fsm_done,
   input  logic [2:0]                   fsm_state,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   queue_count,
   output logic                         order_done,
   output logic [$clog2(N_REQ)-1:0]     order_src,
   output logic                         timeout_err
);

   localparam int PW = $clog2(N_REQ);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int GW = (GAP > 0) ? $clog2(GAP+1) : 1;

   localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
   localparam logic [TW-1:0] TLAST_C = TW'(TIMEOUT-1);
   localparam logic [GW-1:0] GAP_C   = GW'(GAP);
   localparam logic [PW-1:0] LAST_C  = PW'(N_REQ-1);
   localparam logic [PW:0]   NREQ_C  = (PW+1)'(N_REQ);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_BREW,
      S_ABORT,
      S_RECOVER
   } state_t;

   state_t            state_q, state_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic              abort_q, abort_d;
   logic [1:0]        sel_hold_q, sel_hold_d;
   logic              fsm_reset_q;

   logic [PW+1:0]     mem_q [DEPTH];
   logic [AW-1:0]     head_q, head_d;
   logic [AW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     rr_q, rr_d;

   logic [1:0]        sel_a [N_REQ];
   logic [PW:0]       rr_sum;
   logic [PW-1:0]     idx;
   logic [PW-1:0]     win;
   logic [1:0]        win_sel;
   logic              found;
   logic              push;
   logic              pop;
   logic [PW-1:0]     head_src;
   logic [1:0]        head_sel;

   assign head_src    = mem_q[head_q][PW+1:2];
   assign head_sel    = mem_q[head_q][1:0];
   assign busy        = (state_q != S_IDLE);
   assign queue_count = count_q;
   assign fsm_reset   = fsm_reset_q;

   // Intake: nack invalid selections, pick one valid requester round-robin from rr_q.
   always_comb begin
      req_ack  = '0;
      req_nack = '0;
      found    = 1'b0;
      win      = '0;
      win_sel  = 2'b00;
      rr_sum   = '0;
      idx      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_a[i]    = req_sel[2*i +: 2];
         req_nack[i] = req[i] && (req_sel[2*i +: 2] == 2'b11);
      end
      for (int k = 0; k < N_REQ; k++) begin
         rr_sum = {1'b0, rr_q} + (PW+1)'(k);
         if (rr_sum >= NREQ_C) rr_sum = rr_sum - NREQ_C;
         idx = rr_sum[PW-1:0];
         if (!found && req[idx] && (sel_a[idx] != 2'b11)) begin
            found   = 1'b1;
            win     = idx;
            win_sel = sel_a[idx];
         end
      end
      // Uses the registered count: a pop in the same cycle does not open a slot.
      push = found && (count_q != FULL_C);
      if (push) req_ack[win] = 1'b1;
   end

   // FIFO pointer, occupancy and round-robin pointer next-state.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      rr_d    = rr_q;
      if (push) begin
         tail_d = tail_q + 1'b1;
         rr_d   = (win == LAST_C) ? '0 : win + 1'b1;
      end
      if (pop) head_d = head_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   // FIFO storage; entries need no reset since occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= {win, win_sel};
   end

   // FIFO and arbitration registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         rr_q    <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         rr_q    <= rr_d;
      end
   end

   // Dispatch next-state and brewer-facing outputs.
   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      gap_d       = gap_q;
      abort_d     = abort_q;
      sel_hold_d  = sel_hold_q;
      fsm_start   = 1'b0;
      fsm_sel     = 2'b00;
      pop         = 1'b0;
      order_done  = 1'b0;
      timeout_err = 1'b0;
      order_src   = '0;
      case (state_q)
         S_IDLE: begin
            if ((count_q != '0) || push) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            fsm_start  = 1'b1;
            fsm_sel    = head_sel;
            sel_hold_d = head_sel;
            tcnt_d     = '0;
            state_d    = S_BREW;
         end
         S_BREW: begin
            fsm_sel = sel_hold_q;
            tcnt_d  = tcnt_q + 1'b1;
            if (fsm_done) begin
               pop        = 1'b1;
               order_done = 1'b1;
               order_src  = head_src;
               gap_d      = '0;
               state_d    = S_RECOVER;
            end else if (tcnt_q == TLAST_C) begin
               pop         = 1'b1;
               timeout_err = 1'b1;
               order_src   = head_src;
               abort_d     = 1'b0;
               state_d     = S_ABORT;
            end
         end
         S_ABORT: begin
            if (abort_q) begin
               gap_d   = '0;
               state_d = S_RECOVER;
            end else begin
               abort_d = 1'b1;
            end
         end
         S_RECOVER: begin
            // The brewer must sit in IDLE for the whole gap; any excursion restarts it.
            if (fsm_state == 3'd0) begin
               if (gap_q == GAP_C) state_d = S_IDLE;
               else gap_d = gap_q + 1'b1;
            end else begin
               gap_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Dispatch registers; brewer reset is registered so it is held during our reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         tcnt_q      <= '0;
         gap_q       <= '0;
         abort_q     <= 1'b0;
         sel_hold_q  <= 2'b00;
         fsm_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         gap_q       <= gap_d;
         abort_q     <= abort_d;
         sel_hold_q  <= sel_hold_d;
         fsm_reset_q <= (state_d == S_ABORT);
      end
   end

endmodule

// File: tb/tb_coffee_order_scheduler.sv
`timescale 1ns/1ps
// Bench for coffee_order_scheduler: panel drivers, a simple brewer model and an
// issue/completion scoreboard, plus one task per scenario.
module tb_coffee_order_scheduler;

   localparam int N_REQ   = 3;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 32;
   localparam int GAP     = 1;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [N_REQ-1:0]     req = '0;
   logic [2*N_REQ-1:0]   req_sel = '0;
   logic [N_REQ-1:0]     req_ack;
   logic [N_REQ-1:0]     req_nack;
   logic                 fsm_start;
   logic [1:0]           fsm_sel;
   logic                 fsm_reset;
   logic                 fsm_done = 1'b0;
   logic [2:0]           fsm_state = 3'd0;
   logic                 busy;
   logic [2:0]           queue_count;
   logic                 order_done;
   logic [1:0]           order_src;
   logic                 timeout_err;

   int n_checks = 0;
   int n_errors = 0;

   coffee_order_scheduler #(
      .N_REQ(N_REQ), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP(GAP)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_sel(req_sel),
      .req_ack(req_ack), .req_nack(req_nack), .fsm_start(fsm_start),
      .fsm_sel(fsm_sel), .fsm_reset(fsm_reset), .fsm_done(fsm_done),
      .fsm_state(fsm_state), .busy(busy), .queue_count(queue_count),
      .order_done(order_done), .order_src(order_src), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Pending orders per panel; the front entry is what the panel currently presents.
   logic [1:0]       pq [N_REQ][$];
   // Scoreboard of {panel, sel} in the order the brews must be issued.
   logic [3:0]       exp_q [$];

   logic [N_REQ-1:0] s_ack = '0;
   logic             s_start = 1'b0;
   logic             s_frst = 1'b0;
   bit               never_done = 1'b0;
   int               brew_len = 3;
   int               m_cnt = 0;
   logic [2:0]       m_state = 3'd0;

   always @(negedge clk) begin
      s_ack   = req_ack | req_nack;
      s_start = fsm_start;
      s_frst  = fsm_reset;
   end

   // Panels and brewer model, driven just after each rising edge.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N_REQ; i++)
         if (s_ack[i] && pq[i].size() != 0) void'(pq[i].pop_front());
      fsm_done = 1'b0;
      if (s_frst || !reset) begin
         m_state = 3'd0;
         m_cnt   = 0;
      end else if (s_start) begin
         m_state = 3'd2;
         m_cnt   = brew_len;
      end else if (m_state != 3'd0 && !never_done) begin
         if (m_cnt == 0) begin
            fsm_done = 1'b1;
            m_state  = 3'd0;
         end else begin
            m_cnt--;
         end
      end
      fsm_state = m_state;
      for (int i = 0; i < N_REQ; i++) begin
         req[i] = (pq[i].size() != 0);
         req_sel[2*i +: 2] = req[i] ? pq[i][0] : 2'b00;
      end
   end

   // Scoreboard monitor: issue order, held selection, completion source, recovery spacing.
   logic [3:0] cur = '0;
   bit         in_brew = 1'b0;
   int         since_end = 100;

   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         in_brew   = 1'b0;
         since_end = 100;
      end else begin
         if (since_end < 100) since_end++;
         if (fsm_start === 1'b1) begin
            n_checks++;
            if (in_brew || exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL sb_start: start with in_brew=%0b pending=%0d, required no brew and a pending order",
                        in_brew, exp_q.size());
            end else begin
               cur = exp_q.pop_front();
               if (fsm_sel !== cur[1:0]) begin
                  n_errors++;
                  $display("FAIL sb_sel: fsm_sel=%0h, expected %0h", fsm_sel, cur[1:0]);
               end
               n_checks++;
               if (since_end < GAP + 2) begin
                  n_errors++;
                  $display("FAIL sb_gap: start %0d cycles after previous end, required at least %0d",
                           since_end, GAP + 2);
               end
            end
            in_brew = 1'b1;
         end else if (in_brew) begin
            n_checks++;
            if (fsm_sel !== cur[1:0]) begin
               n_errors++;
               $display("FAIL sb_hold: fsm_sel=%0h during brew, expected %0h", fsm_sel, cur[1:0]);
            end
            if (order_done === 1'b1 || timeout_err === 1'b1) begin
               n_checks++;
               if (order_src !== cur[3:2]) begin
                  n_errors++;
                  $display("FAIL sb_src: order_src=%0d, expected %0d", order_src, cur[3:2]);
               end
               in_brew   = 1'b0;
               since_end = 0;
            end
         end else begin
            n_checks++;
            if (order_done !== 1'b0 || timeout_err !== 1'b0 || fsm_sel !== 2'b00) begin
               n_errors++;
               $display("FAIL sb_idle: done=%0b tmo=%0b sel=%0h outside brew, expected 0 0 0",
                        order_done, timeout_err, fsm_sel);
            end
         end
      end
   end

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0 || in_brew) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (busy !== 1'b0 || exp_q.size() != 0 || in_brew) begin
         n_errors++;
         $display("FAIL wait_idle: busy=%0b pending=%0d after %0d cycles, expected idle",
                  busy, exp_q.size(), n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (queue_count !== 3'd0 || busy !== 1'b0 || fsm_start !== 1'b0 || fsm_sel !== 2'b00) begin
         n_errors++;
         $display("FAIL rst_outs: count=%0d busy=%0b start=%0b sel=%0h, expected 0 0 0 0",
                  queue_count, busy, fsm_start, fsm_sel);
      end
      n_checks++;
      if (order_done !== 1'b0 || timeout_err !== 1'b0 || req_ack !== 3'b000 || req_nack !== 3'b000) begin
         n_errors++;
         $display("FAIL rst_pulses: done=%0b tmo=%0b ack=%0b nack=%0b, expected all 0",
                  order_done, timeout_err, req_ack, req_nack);
      end
      n_checks++;
      if (fsm_reset !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_fsm_reset: fsm_reset=%0b, expected 1", fsm_reset);
      end
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if (fsm_reset !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_release_hold: fsm_reset=%0b before first edge, expected 1", fsm_reset);
      end
      @(negedge clk);
      n_checks++;
      if (fsm_reset !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_release: fsm_reset=%0b busy=%0b after first edge, expected 0 0", fsm_reset, busy);
      end
   endtask

   task automatic test_contention();
      @(negedge clk);
      pq[0].push_back(2'b01);
      pq[1].push_back(2'b10);
      pq[2].push_back(2'b00);
      exp_q.push_back({2'd0, 2'b01});
      exp_q.push_back({2'd1, 2'b10});
      exp_q.push_back({2'd2, 2'b00});
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (req_ack !== 3'(1 << k)) begin
            n_errors++;
            $display("FAIL cont_ack%0d: req_ack=%b, expected %b", k, req_ack, 3'(1 << k));
         end
      end
      @(negedge clk);
      n_checks++;
      if (req_ack !== 3'b000 || queue_count !== 3'd3) begin
         n_errors++;
         $display("FAIL cont_queued: ack=%b count=%0d, expected 000 3", req_ack, queue_count);
      end
      wait_idle(200);
      // Pointer must have wrapped to 0: panel 0 beats panel 1.
      pq[1].push_back(2'b01);
      pq[0].push_back(2'b00);
      exp_q.push_back({2'd0, 2'b00});
      exp_q.push_back({2'd1, 2'b01});
      @(negedge clk);
      n_checks++;
      if (req_ack !== 3'b001) begin
         n_errors++;
         $display("FAIL cont_rr_wrap: req_ack=%b, expected 001", req_ack);
      end
      @(negedge clk);
      n_checks++;
      if (req_ack !== 3'b010) begin
         n_errors++;
         $display("FAIL cont_rr_next: req_ack=%b, expected 010", req_ack);
      end
      wait_idle(200);
   endtask

   task automatic test_single();
      int n;
      @(negedge clk);
      pq[0].push_back(2'b00);
      exp_q.push_back({2'd0, 2'b00});
      @(negedge clk);
      n_checks++;
      if (req_ack !== 3'b001 || fsm_start !== 1'b0) begin
         n_errors++;
         $display("FAIL single_ack: ack=%b start=%0b, expected 001 0", req_ack, fsm_start);
      end
      @(negedge clk);
      n_checks++;
      if (fsm_start !== 1'b1 || fsm_sel !== 2'b00 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL single_issue: start=%0b sel=%0h busy=%0b, expected 1 0 1", fsm_start, fsm_sel, busy);
      end
      n = 0;
      while (order_done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (order_done !== 1'b1 || order_src !== 2'd0) begin
         n_errors++;
         $display("FAIL single_done: done=%0b src=%0d, expected 1 0", order_done, order_src);
      end
      @(negedge clk);
      n_checks++;
      if (queue_count !== 3'd0) begin
         n_errors++;
         $display("FAIL single_count: count=%0d, expected 0", queue_count);
      end
      wait_idle(50);
   endtask

   task automatic test_invalid();
      @(negedge clk);
      pq[2].push_back(2'b11);
      pq[0].push_back(2'b00);
      exp_q.push_back({2'd0, 2'b00});
      @(negedge clk);
      n_checks++;
      if (req_nack !== 3'b100 || req_ack !== 3'b001) begin
         n_errors++;
         $display("FAIL inv_ack: nack=%b ack=%b, expected 100 001", req_nack, req_ack);
      end
      @(negedge clk);
      n_checks++;
      if (queue_count !== 3'd1 || req_nack !== 3'b000) begin
         n_errors++;
         $display("FAIL inv_count: count=%0d nack=%b, expected 1 000", queue_count, req_nack);
      end
      wait_idle(50);
   endtask

   task automatic test_timeout();
      int  n;
      bit  early;
      @(negedge clk);
      never_done = 1'b1;
      // Pointer sits at 1 here, so panel 1 is served before panel 2.
      pq[1].push_back(2'b10);
      pq[2].push_back(2'b01);
      exp_q.push_back({2'd1, 2'b10});
      exp_q.push_back({2'd2, 2'b01});
      n = 0;
      while (fsm_start !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (fsm_start !== 1'b1) begin
         n_errors++;
         $display("FAIL to_start: no start within %0d cycles, expected one", n);
      end
      early = 1'b0;
      for (int k = 1; k < TIMEOUT; k++) begin
         @(negedge clk);
         if (timeout_err !== 1'b0 || order_done !== 1'b0) early = 1'b1;
      end
      n_checks++;
      if (early) begin
         n_errors++;
         $display("FAIL to_early: completion seen before %0d cycles, expected none", TIMEOUT);
      end
      @(negedge clk);
      n_checks++;
      if (timeout_err !== 1'b1 || order_src !== 2'd1 || fsm_reset !== 1'b0) begin
         n_errors++;
         $display("FAIL to_pulse: tmo=%0b src=%0d rst=%0b, expected 1 1 0", timeout_err, order_src, fsm_reset);
      end
      never_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (fsm_reset !== (k < 2)) begin
            n_errors++;
            $display("FAIL to_fsm_reset%0d: fsm_reset=%0b, expected %0b", k, fsm_reset, k < 2);
         end
      end
      n = 0;
      while (fsm_start !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (fsm_start !== 1'b1 || fsm_state !== 3'd0) begin
         n_errors++;
         $display("FAIL to_next: start=%0b brewer_state=%0d, expected 1 0", fsm_start, fsm_state);
      end
      wait_idle(100);
   endtask

   task automatic test_full();
      int n;
      logic [1:0] sels [5];
      sels = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
      @(negedge clk);
      never_done = 1'b1;
      for (int k = 0; k < 5; k++) begin
         pq[1].push_back(sels[k]);
         exp_q.push_back({2'd1, sels[k]});
      end
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clk);
         n_checks++;
         if (req_ack !== 3'b010) begin
            n_errors++;
            $display("FAIL full_ack%0d: req_ack=%b, expected 010", k, req_ack);
         end
      end
      @(negedge clk);
      n_checks++;
      if (queue_count !== 3'd4 || req_ack !== 3'b000 || req[1] !== 1'b1) begin
         n_errors++;
         $display("FAIL full_hold: count=%0d ack=%b req1=%0b, expected 4 000 1", queue_count, req_ack, req[1]);
      end
      n = 0;
      while (timeout_err !== 1'b1 && n < TIMEOUT + 8) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (timeout_err !== 1'b1 || req_ack !== 3'b000 || queue_count !== 3'd4) begin
         n_errors++;
         $display("FAIL full_pop: tmo=%0b ack=%b count=%0d, expected 1 000 4", timeout_err, req_ack, queue_count);
      end
      never_done = 1'b0;
      @(negedge clk);
      n_checks++;
      if (req_ack !== 3'b010) begin
         n_errors++;
         $display("FAIL full_reack: req_ack=%b one cycle after pop, expected 010", req_ack);
      end
      wait_idle(400);
   endtask

   task automatic test_reset_mid_brew();
      int n;
      bit bad;
      @(negedge clk);
      never_done = 1'b1;
      pq[0].push_back(2'b00);
      pq[0].push_back(2'b01);
      pq[0].push_back(2'b10);
      for (int k = 0; k < 3; k++) exp_q.push_back({2'd0, 2'(k)});
      n = 0;
      while (fsm_start !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if (queue_count !== 3'd3 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_pre: count=%0d busy=%0b, expected 3 1", queue_count, busy);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (queue_count !== 3'd0 || busy !== 1'b0 || fsm_reset !== 1'b1 || fsm_start !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_async: count=%0d busy=%0b rst=%0b start=%0b, expected 0 0 1 0",
                  queue_count, busy, fsm_reset, fsm_start);
      end
      @(negedge clk);
      #1 reset = 1'b1;
      never_done = 1'b0;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (fsm_start !== 1'b0 || busy !== 1'b0 || queue_count !== 3'd0) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
         n_errors++;
         $display("FAIL mid_quiet: activity after reset without requests, expected none");
      end
      pq[2].push_back(2'b01);
      exp_q.push_back({2'd2, 2'b01});
      @(negedge clk);
      n_checks++;
      if (req_ack !== 3'b100) begin
         n_errors++;
         $display("FAIL mid_new_ack: req_ack=%b, expected 100", req_ack);
      end
      wait_idle(50);
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single();
      test_invalid();
      test_timeout();
      test_full();
      test_reset_mid_brew();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
